// File: rtl/l1_refill_pkg.sv
// l1_refill_pkg: shared types for the L1 refill path.
//   BlockPos      - packed (x,y,z) block position inside the store
//   BlockType     - block type code returned by the backing store
//   LANES_DEFAULT - default number of L1 lookup lanes
package l1_refill_pkg;

    localparam int LANES_DEFAULT = 4;
    localparam int POS_W         = 4;

    typedef struct packed {
        logic [POS_W-1:0] x;
        logic [POS_W-1:0] y;
        logic [POS_W-1:0] z;
    } BlockPos;

    typedef logic [7:0] BlockType;

endpackage

// File: rtl/l1_refill_if.sv
// l1_refill_if: miss / block-store / fill bundle between the L1 lanes,
// the refill engine and the backing block store.
//   miss_valid/miss_addr/miss_ready - per-lane miss handshake
//   mem_en/mem_addr/mem_rdata       - fixed-latency block-store read port
//   fill_valid/addr/data/lanes      - one-cycle fill pulse back to the L1
// master: the L1 + block store side.  slave: the refill engine.
interface l1_refill_if
    import l1_refill_pkg::*;
#(
    parameter int LANES = LANES_DEFAULT
) ();

    logic    [LANES-1:0] miss_valid;
    BlockPos [LANES-1:0] miss_addr;
    logic    [LANES-1:0] miss_ready;

    logic     mem_en;
    BlockPos  mem_addr;
    BlockType mem_rdata;

    logic             fill_valid;
    BlockPos          fill_addr;
    BlockType         fill_data;
    logic [LANES-1:0] fill_lanes;

    modport master (
        output miss_valid, miss_addr, mem_rdata,
        input  miss_ready, mem_en, mem_addr,
        input  fill_valid, fill_addr, fill_data, fill_lanes
    );

    modport slave (
        input  miss_valid, miss_addr, mem_rdata,
        output miss_ready, mem_en, mem_addr,
        output fill_valid, fill_addr, fill_data, fill_lanes
    );

endinterface

// File: rtl/l1_refill_rr_arbiter.sv
// rr_arbiter: round-robin winner selection.
//   clk_in, rst_in - clock, synchronous active-high reset
//   req            - request mask
//   gnt            - one-hot grant (zero when req is zero)
// Priority starts at the lane after the last winner; the pointer only
// moves when a grant is issued. Reset makes lane 0 the top priority.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] last;
    logic          found;

    // First pass: lanes above the last winner; second pass wraps to 0.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (i > int'(last))) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (i <= int'(last))) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            last <= PW'(N - 1);
        end else begin
            for (int i = 0; i < N; i++) begin
                if (gnt[i]) last <= PW'(i);
            end
        end
    end

endmodule

// File: rtl/l1_refill.sv
// l1_refill: coalescing refill engine between L1 lookup lanes and a
// fixed-latency block store.
//   clk_in, rst_in - clock, synchronous active-high reset
//   bus (slave)    - miss handshake, block-store read port, fill output
// Misses to one address are coalesced in the grant cycle and merged into
// an in-flight read while it is outstanding, so each address is read once
// and filled once with the mask of every lane it satisfies.
module l1_refill
    import l1_refill_pkg::*;
#(
    parameter int LANES       = LANES_DEFAULT,
    parameter int MEM_LATENCY = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    l1_refill_if.slave  bus
);

    // Stage 0 holds an entry the cycle its read is on mem_en; the last
    // stage is the cycle its data is on mem_rdata.
    localparam int DEPTH = MEM_LATENCY + 1;

    logic    [DEPTH-1:0]            st_vld;
    BlockPos [DEPTH-1:0]            st_addr;
    logic    [DEPTH-1:0][LANES-1:0] st_mask;

    logic [DEPTH-1:0][LANES-1:0] hit;
    logic [LANES-1:0]            merged;
    logic [LANES-1:0]            req;
    logic [LANES-1:0]            gnt;
    logic [LANES-1:0]            coal;
    logic                        any_gnt;
    BlockPos                     win_addr;

    // Lanes matching an outstanding read join it instead of competing.
    always_comb begin
        hit    = '0;
        merged = '0;
        for (int s = 0; s < DEPTH; s++) begin
            for (int l = 0; l < LANES; l++) begin
                hit[s][l] = !rst_in && bus.miss_valid[l] && st_vld[s] &&
                            (bus.miss_addr[l] == st_addr[s]);
                merged[l] = merged[l] | hit[s][l];
            end
        end
    end

    assign req = bus.miss_valid & ~merged & {LANES{!rst_in}};

    rr_arbiter #(.N(LANES)) u_arb (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .req    (req),
        .gnt    (gnt)
    );

    assign any_gnt = |gnt;

    always_comb begin
        win_addr = '0;
        for (int l = 0; l < LANES; l++) begin
            if (gnt[l]) win_addr = bus.miss_addr[l];
        end
    end

    // Every competing lane asking for the winner's address rides along.
    always_comb begin
        coal = '0;
        for (int l = 0; l < LANES; l++) begin
            coal[l] = req[l] && any_gnt && (bus.miss_addr[l] == win_addr);
        end
    end

    assign bus.miss_ready = merged | coal;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            st_vld         <= '0;
            st_addr        <= '0;
            st_mask        <= '0;
            bus.mem_en     <= 1'b0;
            bus.mem_addr   <= '0;
            bus.fill_valid <= 1'b0;
            bus.fill_addr  <= '0;
            bus.fill_data  <= '0;
            bus.fill_lanes <= '0;
        end else begin
            st_vld[0]  <= any_gnt;
            st_addr[0] <= win_addr;
            st_mask[0] <= coal;
            // Merges land on the entry as it advances, including the one
            // leaving the last stage for the fill register.
            for (int s = 1; s < DEPTH; s++) begin
                st_vld[s]  <= st_vld[s-1];
                st_addr[s] <= st_addr[s-1];
                st_mask[s] <= st_mask[s-1] | hit[s-1];
            end

            bus.mem_en   <= any_gnt;
            bus.mem_addr <= win_addr;

            bus.fill_valid <= st_vld[DEPTH-1];
            if (st_vld[DEPTH-1]) begin
                bus.fill_addr  <= st_addr[DEPTH-1];
                bus.fill_data  <= bus.mem_rdata;
                bus.fill_lanes <= st_mask[DEPTH-1] | hit[DEPTH-1];
            end else begin
                bus.fill_addr  <= '0;
                bus.fill_data  <= '0;
                bus.fill_lanes <= '0;
            end
        end
    end

endmodule

// File: tb/tb_l1_refill.sv
// tb_l1_refill: directed scenarios followed by randomized misses. The
// stimulus process predicts each cycle's accepts from the refill rules
// (pending reads kept as a list, not a pipeline) and queues expected reads
// and fills; a negedge monitor pops and compares them against the DUT.
module tb_l1_refill;
    import l1_refill_pkg::*;

    localparam int LANES = LANES_DEFAULT;
    localparam int LAT   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    l1_refill_if #(.LANES(LANES)) bus ();

    l1_refill #(.LANES(LANES), .MEM_LATENCY(LAT)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    function automatic BlockType store(input BlockPos p);
        return BlockType'(p.x * 8'd7 + p.y * 8'd3 + p.z * 8'd5 + 8'd1);
    endfunction

    // Block store: data for a read shows up LAT cycles after mem_en;
    // other cycles carry junk so a fill from a wrong cycle shows up.
    logic    mp_v [LAT];
    BlockPos mp_a [LAT];
    BlockType junk = '0;
    initial for (int i = 0; i < LAT; i++) begin mp_v[i] = 1'b0; mp_a[i] = '0; end
    always @(posedge clk) begin
        mp_v[0] <= bus.mem_en;
        mp_a[0] <= bus.mem_addr;
        for (int i = 1; i < LAT; i++) begin
            mp_v[i] <= mp_v[i-1];
            mp_a[i] <= mp_a[i-1];
        end
        junk <= BlockType'($urandom);
    end
    assign bus.mem_rdata = mp_v[LAT-1] ? store(mp_a[LAT-1]) : junk;

    typedef struct { BlockPos addr; logic [LANES-1:0] lanes; int due; } fill_t;
    typedef struct { BlockPos addr; int due; } rd_t;
    fill_t fillq[$];
    rd_t   memq[$];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;
    int ptr;
    bit mon_on = 1'b0;
    bit      hold [LANES];
    BlockPos haddr [LANES];
    int      wait_cnt [LANES];

    function automatic BlockPos pos(input int x, input int y, input int z);
        BlockPos p;
        p.x = POS_W'(x); p.y = POS_W'(y); p.z = POS_W'(z);
        return p;
    endfunction

    // One clock: drive held requests, predict accepts/reads/fills, check.
    task automatic step(input bit r);
        logic [LANES-1:0] exp_rdy;
        logic [LANES-1:0] lm;
        bit               cand [LANES];
        bit               m;
        int               win, j;
        BlockPos          wa;
        @(posedge clk);
        #1;
        rst = r;
        for (int i = 0; i < LANES; i++) begin
            bus.miss_valid[i] = hold[i];
            bus.miss_addr[i]  = hold[i] ? haddr[i] : '0;
        end
        #1;
        exp_rdy = '0;
        if (r) begin
            // Outputs already registered this cycle still appear.
            while (fillq.size() > 0 && fillq[$].due > cyc) void'(fillq.pop_back());
            while (memq.size() > 0 && memq[$].due > cyc) void'(memq.pop_back());
            ptr = LANES - 1;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                cand[i] = 1'b0;
                m = 1'b0;
                if (hold[i]) begin
                    // Outstanding: granted before this cycle, not yet filling.
                    foreach (fillq[e]) begin
                        if (fillq[e].due > cyc && fillq[e].due - LAT - 2 < cyc &&
                            fillq[e].addr == haddr[i]) begin
                            fillq[e].lanes[i] = 1'b1;
                            m = 1'b1;
                        end
                    end
                    if (m) exp_rdy[i] = 1'b1;
                    else   cand[i] = 1'b1;
                end
            end
            win = -1;
            for (int k = 1; k <= LANES; k++) begin
                j = (ptr + k) % LANES;
                if (win < 0 && cand[j]) win = j;
            end
            if (win >= 0) begin
                wa = haddr[win];
                lm = '0;
                for (int i = 0; i < LANES; i++) begin
                    if (cand[i] && haddr[i] == wa) begin
                        exp_rdy[i] = 1'b1;
                        lm[i] = 1'b1;
                    end
                end
                fillq.push_back('{addr: wa, lanes: lm, due: cyc + LAT + 2});
                memq.push_back('{addr: wa, due: cyc + 1});
                ptr = win;
            end
        end
        n_cmp++;
        if (bus.miss_ready !== exp_rdy) begin
            n_err++;
            $display("FAIL miss_ready cyc=%0d got=%b exp=%b", cyc, bus.miss_ready, exp_rdy);
        end
        // No held lane may be passed over more than LANES-1 cycles.
        for (int i = 0; i < LANES; i++) begin
            if (hold[i] && !r && !bus.miss_ready[i]) wait_cnt[i]++;
            else wait_cnt[i] = 0;
            if (hold[i] && !r) begin
                n_cmp++;
                if (wait_cnt[i] > LANES - 1) begin
                    n_err++;
                    $display("FAIL starve lane=%0d cyc=%0d waited=%0d max=%0d", i, cyc, wait_cnt[i], LANES - 1);
                end
            end
            if (exp_rdy[i]) hold[i] = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            n_cmp++;
            if (memq.size() > 0 && memq[0].due == cyc) begin
                if (bus.mem_en !== 1'b1 || bus.mem_addr !== memq[0].addr) begin
                    n_err++;
                    $display("FAIL mem_read cyc=%0d got en=%b addr=%h exp en=1 addr=%h",
                             cyc, bus.mem_en, bus.mem_addr, memq[0].addr);
                end
                void'(memq.pop_front());
            end else if (bus.mem_en !== 1'b0) begin
                n_err++;
                $display("FAIL mem_idle cyc=%0d got en=%b exp en=0", cyc, bus.mem_en);
            end
            n_cmp++;
            if (fillq.size() > 0 && fillq[0].due == cyc) begin
                if (bus.fill_valid !== 1'b1 || bus.fill_addr !== fillq[0].addr ||
                    bus.fill_data !== store(fillq[0].addr) || bus.fill_lanes !== fillq[0].lanes) begin
                    n_err++;
                    $display("FAIL fill cyc=%0d got v=%b a=%h d=%h l=%b exp v=1 a=%h d=%h l=%b",
                             cyc, bus.fill_valid, bus.fill_addr, bus.fill_data, bus.fill_lanes,
                             fillq[0].addr, store(fillq[0].addr), fillq[0].lanes);
                end
                void'(fillq.pop_front());
            end else if (bus.fill_valid !== 1'b0 || bus.fill_addr !== '0 ||
                         bus.fill_data !== '0 || bus.fill_lanes !== '0) begin
                n_err++;
                $display("FAIL fill_idle cyc=%0d got v=%b a=%h d=%h l=%b exp all zero",
                         cyc, bus.fill_valid, bus.fill_addr, bus.fill_data, bus.fill_lanes);
            end
        end
    end

    function automatic bit busy();
        bit b = (fillq.size() > 0) || (memq.size() > 0);
        for (int i = 0; i < LANES; i++) b |= hold[i];
        return b;
    endfunction

    initial begin
        int n;
        bus.miss_valid = '0;
        bus.miss_addr  = '0;
        ptr = LANES - 1;
        for (int i = 0; i < LANES; i++) begin
            hold[i] = 1'b0; haddr[i] = '0; wait_cnt[i] = 0;
        end
        step(1); step(1);
        mon_on = 1'b1;

        // Single miss from lane 0.
        hold[0] = 1'b1; haddr[0] = pos(1, 2, 3);
        repeat (8) step(0);

        // Four distinct misses at once, fresh priority.
        step(1);
        for (int i = 0; i < LANES; i++) begin hold[i] = 1'b1; haddr[i] = pos(i + 1, 9, 4); end
        repeat (10) step(0);

        // Same-cycle coalescing.
        hold[1] = 1'b1; haddr[1] = pos(5, 5, 5);
        hold[3] = 1'b1; haddr[3] = pos(5, 5, 5);
        repeat (8) step(0);

        // Merge into an outstanding read.
        hold[0] = 1'b1; haddr[0] = pos(7, 0, 0);
        step(0); step(0);
        hold[2] = 1'b1; haddr[2] = pos(7, 0, 0);
        repeat (8) step(0);

        // Reset two cycles after a grant, with a lane waiting through it.
        hold[1] = 1'b1; haddr[1] = pos(2, 2, 2);
        step(0); step(0);
        hold[0] = 1'b1; haddr[0] = pos(3, 3, 3);
        step(1);
        hold[3] = 1'b1; haddr[3] = pos(4, 4, 4);
        repeat (8) step(0);

        // Lane 2 held while lanes 0 and 1 keep re-requesting.
        hold[2] = 1'b1; haddr[2] = pos(9, 9, 9);
        repeat (8) begin
            for (int i = 0; i < 2; i++) begin
                if (!hold[i]) begin
                    hold[i] = 1'b1;
                    haddr[i] = pos($urandom_range(10, 15), i, $urandom_range(0, 15));
                end
            end
            step(0);
        end
        repeat (8) step(0);

        // Random traffic over a small address pool to force collisions.
        repeat (3000) begin
            for (int i = 0; i < LANES; i++) begin
                if (!hold[i] && $urandom_range(0, 1) == 1) begin
                    hold[i] = 1'b1;
                    haddr[i] = pos($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
                end
            end
            step($urandom_range(0, 199) == 0);
        end

        // Drain with no new misses; bounded.
        n = 0;
        while (busy() && n < 50) begin step(0); n++; end
        step(0);
        n_cmp++;
        if (busy()) begin
            n_err++;
            $display("FAIL drain pending fills=%0d reads=%0d exp 0", fillq.size(), memq.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/l1_refill.md
L1_REFILL -- requirements
Module: l1_refill

Interface
REQ-001 Parameter LANES, default 4: number of L1 lookup lanes served.
REQ-002 Parameter MEM_LATENCY, default 2: fixed read latency of the backing block store, in cycles from mem_en to mem_rdata.
REQ-003 clk_in  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_in  input  1  synchronous, active-high reset.
REQ-005 miss_valid  input  LANES  per-lane miss request; held high until accepted.
REQ-006 miss_addr  input  LANES x BlockPos  per-lane missed block position; stable while miss_valid is high.
REQ-007 miss_ready  output  LANES  combinational per-lane accept; a transfer occurs when miss_valid and miss_ready are both high.
REQ-008 mem_en  output  1  registered read strobe to the block store.
REQ-009 mem_addr  output  BlockPos  registered read address, valid when mem_en is high.
REQ-010 mem_rdata  input  BlockType  read data, valid exactly MEM_LATENCY cycles after mem_en.
REQ-011 fill_valid  output  1  registered one-cycle pulse; L1 always accepts, no backpressure.
REQ-012 fill_addr  output  BlockPos  block position being filled.
REQ-013 fill_data  output  BlockType  block type for fill_addr.
REQ-014 fill_lanes  output  LANES  mask of lanes whose misses this fill satisfies.

Function
REQ-015 Each cycle with any miss_valid high, one winner is chosen round-robin, starting from the lane after the last winner and wrapping from LANES-1 to 0.
REQ-016 In the grant cycle T, miss_ready is high for the winner and for every other valid lane whose miss_addr equals the winner's (same-cycle coalescing).
REQ-017 A valid lane whose miss_addr matches an in-flight entry (issued, not yet in the fill register) is accepted in that cycle and ORed into that entry's lane mask; it is not a winner and issues no read.
REQ-018 In-flight merging takes priority over new-winner selection for that lane; non-matching lanes still compete for the winner.
REQ-019 A granted non-merged address issues mem_en=1, mem_addr=addr at T+1; the fill appears at T+2+MEM_LATENCY (T+4 at default) with fill_lanes = all lanes accepted for that address up to T+1+MEM_LATENCY.
REQ-020 A merge arriving in the same cycle the entry moves into the fill register is included in that fill_lanes.
REQ-021 Throughput is one new read per cycle; up to MEM_LATENCY+1 entries in flight; no two in-flight entries share an address.
REQ-022 The round-robin pointer advances only to the winner; coalesced and merged lanes do not move it.
REQ-023 With no miss_valid high, miss_ready is all zero, mem_en is 0 next cycle, and the pointer holds.
REQ-024 fill_addr, fill_data and fill_lanes are zero whenever fill_valid is 0.

Reset
REQ-025 Reset clears all in-flight entries, fill_valid, mem_en, and all outputs to zero, and sets the pointer so lane 0 has top priority.
REQ-026 Reset mid-operation discards in-flight reads; mem_rdata arriving after reset produces no fill.
REQ-027 miss_ready is all zero during any cycle rst_in is high.

Structure
REQ-028 BlockPos and BlockType come from the shared types package; the default LANES constant lives there as well.
REQ-029 Winner selection is a sub-module rr_arbiter (request mask in, one-hot grant out, pointer state inside).
REQ-030 In-flight tracking is a MEM_LATENCY+1-deep shift register of {valid, addr, lane mask} with per-stage address comparators.

Verification
REQ-031 After reset, lane 0 misses (1,2,3) at T -> miss_ready=0001 at T; mem_en, mem_addr=(1,2,3) at T+1; fill_valid, fill_lanes=0001, fill_data=store[(1,2,3)] at T+4.
REQ-032 All 4 lanes miss distinct addresses held at once -> granted in order 0,1,2,3 on consecutive cycles; fills on 4 consecutive cycles.
REQ-033 Lanes 1 and 3 miss (5,5,5) in the same cycle -> a single mem read; one fill with fill_lanes=1010.
REQ-034 Lane 0 accepted for (7,0,0) at T; lane 2 misses (7,0,0) at T+2 -> accepted at T+2, no second read, fill at T+4 with fill_lanes=0101.
REQ-035 rst_in pulsed at T+2 after a grant at T -> no fill_valid through T+6; lane 0 has priority on the next request.
REQ-036 Lane 2 held valid continuously while lanes 0 and 1 keep re-requesting -> lane 2 granted within 3 cycles (no starvation).
